// File: rtl/sys_bus_rsp_pkg.sv
// Shared types and address-map constants for the system bus register responder.
package sys_bus_rsp_pkg;

    localparam int unsigned CTL_BASE = 32'h000;
    localparam int unsigned STS_BASE = 32'h800;
    localparam int unsigned PLS_ADR  = 32'hC00;

    // Each region spans a 1 KiB page; index is the word offset inside it.
    localparam int unsigned PAGE_SH = 10;
    localparam int unsigned IDX_W   = 8;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    typedef enum logic [1:0] {
        RGN_NONE,
        RGN_CTL,
        RGN_STS,
        RGN_PLS
    } region_t;

    typedef struct packed {
        region_t          region;
        logic [IDX_W-1:0] idx;
        logic             err;
    } dec_t;

endpackage

// File: rtl/sys_bus_rsp_decode.sv
// Combinational address decode: region, word index and access error flag.
module sys_bus_rsp_decode
    import sys_bus_rsp_pkg::*;
#(
    parameter int unsigned SW = 20,
    parameter int unsigned NR = 8,
    parameter int unsigned NS = 4
) (
    input  logic [SW-1:0] addr,
    input  logic          wen,
    input  logic          ren,
    output dec_t          dec
);

    localparam logic [IDX_W:0] NR_LIM = (IDX_W+1)'(NR);
    localparam logic [IDX_W:0] NS_LIM = (IDX_W+1)'(NS);

    logic [SW-1:0]    page;
    logic [IDX_W-1:0] word;

    assign page = addr >> PAGE_SH;
    assign word = addr[IDX_W+1:2];

    // Classify the address; misaligned or out-of-range offsets stay unmapped.
    always_comb begin
        dec        = '0;
        dec.region = RGN_NONE;
        dec.idx    = word;
        if (addr[1:0] == 2'b00) begin
            if (addr == SW'(PLS_ADR)) begin
                dec.region = RGN_PLS;
            end else if (page == SW'(CTL_BASE >> PAGE_SH) && {1'b0, word} < NR_LIM) begin
                dec.region = RGN_CTL;
            end else if (page == SW'(STS_BASE >> PAGE_SH) && {1'b0, word} < NS_LIM) begin
                dec.region = RGN_STS;
            end
        end
        dec.err = (dec.region == RGN_NONE) || (wen && dec.region == RGN_STS) || (wen && ren);
    end

endmodule

// File: rtl/sys_bus_reg_responder.sv
// System bus slave responder terminating accesses on a small register bank.
// Optional build macro SYS_BUS_RSP_SHADOW_EN: control writes land in shadow
// registers that are copied to ctl_o on upd_i or a pulse write with wdata[31].
module sys_bus_reg_responder
    import sys_bus_rsp_pkg::*;
#(
    parameter int unsigned             SW      = 20,
    parameter int unsigned             NR      = 8,
    parameter int unsigned             NS      = 4,
    parameter int unsigned             WS      = 0,
    parameter logic [NR-1:0][31:0]     RST_VAL = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [31:0]            sys_addr,
    input  logic [31:0]            sys_wdata,
    input  logic                   sys_wen,
    input  logic                   sys_ren,
    output logic [31:0]            sys_rdata,
    output logic                   sys_err,
    output logic                   sys_ack,
    output logic [NR-1:0][31:0]    ctl_o,
    input  logic [NS-1:0][31:0]    sts_i,
    output logic [31:0]            pls_o,
    input  logic                   upd_i
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WS == 0 ? 0 : WS - 1);

    dec_t                  dec;
    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [31:0]           rd_q;
    logic                  err_q;
    logic                  acc_c;
    logic                  wr_ok_c;
    logic                  ctl_wr_c;
    logic                  pls_wr_c;
    logic [31:0]           rd_c;
    logic [31:0]           rd_cap_c;
    logic [NR-1:0][31:0]   bank_c;
    logic [NR-1:0][31:0]   bank_nxt_c;
    logic                  unused_bits;

    sys_bus_rsp_decode #(
        .SW (SW),
        .NR (NR),
        .NS (NS)
    ) u_decode (
        .addr (sys_addr[SW-1:0]),
        .wen  (sys_wen),
        .ren  (sys_ren),
        .dec  (dec)
    );

    // Only IDLE accepts strobes; errored accesses have no side effects.
    assign acc_c    = (state == IDLE) && (sys_wen || sys_ren);
    assign wr_ok_c  = acc_c && sys_wen && !dec.err;
    assign ctl_wr_c = wr_ok_c && (dec.region == RGN_CTL);
    assign pls_wr_c = wr_ok_c && (dec.region == RGN_PLS);
    assign rd_cap_c = (sys_ren && !dec.err) ? rd_c : '0;

    // Next value of the writable bank with this cycle's control write merged in.
    always_comb begin
        bank_nxt_c = bank_c;
        for (int unsigned k = 0; k < NR; k++) begin
            if (ctl_wr_c && dec.idx == IDX_W'(k)) begin
                bank_nxt_c[k] = sys_wdata;
            end
        end
    end

    // Read mux; the pulse register and unmapped space read as zero.
    always_comb begin
        rd_c = '0;
        if (dec.region == RGN_CTL) begin
            for (int unsigned k = 0; k < NR; k++) begin
                if (dec.idx == IDX_W'(k)) rd_c = bank_c[k];
            end
        end else if (dec.region == RGN_STS) begin
            for (int unsigned k = 0; k < NS; k++) begin
                if (dec.idx == IDX_W'(k)) rd_c = sts_i[k];
            end
        end
    end

`ifdef SYS_BUS_RSP_SHADOW_EN
    logic [NR-1:0][31:0] shd_q;

    assign bank_c      = shd_q;
    assign unused_bits = ^sys_addr[31:SW];

    // Shadow bank takes writes; ctl_o copies all shadows on an update request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shd_q <= RST_VAL;
            ctl_o <= RST_VAL;
        end else begin
            shd_q <= bank_nxt_c;
            if (upd_i || (pls_wr_c && sys_wdata[31])) begin
                ctl_o <= bank_nxt_c;
            end
        end
    end
`else
    assign bank_c      = ctl_o;
    assign unused_bits = ^{sys_addr[31:SW], upd_i};

    // Control registers commit at the edge ending the strobe cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctl_o <= RST_VAL;
        end else begin
            ctl_o <= bank_nxt_c;
        end
    end
`endif

    // Access FSM: capture in IDLE, count wait states, one-cycle ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_q      <= '0;
            err_q     <= 1'b0;
            sys_ack   <= 1'b0;
            sys_err   <= 1'b0;
            sys_rdata <= '0;
            pls_o     <= '0;
        end else begin
            sys_ack   <= 1'b0;
            sys_err   <= 1'b0;
            sys_rdata <= '0;
            pls_o     <= pls_wr_c ? sys_wdata : '0;
            case (state)
                IDLE: begin
                    if (acc_c) begin
                        rd_q  <= rd_cap_c;
                        err_q <= dec.err;
                        if (WS == 0) begin
                            state     <= ACK;
                            sys_ack   <= 1'b1;
                            sys_err   <= dec.err;
                            sys_rdata <= rd_cap_c;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state     <= ACK;
                        sys_ack   <= 1'b1;
                        sys_err   <= err_q;
                        sys_rdata <= rd_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
